// File: rtl/tt_sweep_pkg.sv
// ============================================================================
// Module   : tt_sweep_pkg
// Brief    : Shared sweep-controller types, defaults and signature step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OUT    = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

   localparam int c_SIG_W_DEF = 16;
   localparam int c_SIG_W_MAX = 64;

   // Rotate the low w bits left by one, then fold in din; sig must be zero above bit w-1.
   function automatic logic [c_SIG_W_MAX-1:0] sig_step(
      input logic [c_SIG_W_MAX-1:0] sig,
      input logic [c_SIG_W_MAX-1:0] din,
      input int                     w
   );
      logic [c_SIG_W_MAX-1:0] mask;
      mask = (w >= c_SIG_W_MAX) ? '1
           : ((c_SIG_W_MAX'(1) << w) - c_SIG_W_MAX'(1));
      return (((sig << 1) | (sig >> (w - 1))) & mask) ^ din;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sweep_sig.sv
// ============================================================================
// Module   : tt_sweep_sig
// Brief    : Rotate-XOR signature register with clear and update enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweep_sig
   import tt_sweep_pkg::*;
#(
   parameter int N_OUT = 3,
   parameter int SIG_W = c_SIG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_upd,
   input  logic [N_OUT-1:0] i_data,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (i_clr) begin
         r_sig <= '0;
      end else if (i_upd) begin
         r_sig <= SIG_W'(sig_step(c_SIG_W_MAX'(r_sig), c_SIG_W_MAX'(i_data), SIG_W));
      end
   end

   assign o_sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
// ============================================================================
// Module   : tt_sweep_ctrl
// Brief    : Exhaustive truth-table sweeper with valid/ready result stream.
//            Optional expected-output checking when TT_SWEEP_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 3,
   parameter int SETTLE = 2,
   parameter int SIG_W  = c_SIG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   output logic [N_IN-1:0]  o_dut_in,
   input  logic [N_OUT-1:0] i_dut_out,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [N_IN-1:0]  o_res_idx,
   output logic [N_OUT-1:0] o_res_data,
   output logic [SIG_W-1:0] o_signature
`ifdef TT_SWEEP_CHECK_EN
   ,
   input  logic [N_OUT-1:0] i_exp_out,
   output logic [N_IN:0]    o_err_cnt,
   output logic             o_err_seen,
   output logic [N_IN-1:0]  o_first_err_idx
`endif
);

   localparam int              c_CW       = $clog2(SETTLE + 1);
   localparam logic [N_IN-1:0] c_IDX_LAST = '1;

   sweep_state_t     r_state;
   logic [c_CW-1:0]  r_cnt;
   logic [N_IN-1:0]  r_idx;
   logic [N_IN-1:0]  r_dut_in;
   logic             r_busy;
   logic             r_done;
   logic             r_res_valid;
   logic [N_IN-1:0]  r_res_idx;
   logic [N_OUT-1:0] r_res_data;

   logic             w_start_ok;
   logic             w_capture;

   assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start && !i_abort;
   assign w_capture  = (r_state == ST_SETTLE) && !i_abort && (r_cnt == c_CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_dut_in    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_idx   <= '0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) begin
                  r_idx    <= '0;
                  r_dut_in <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_cnt    <= c_CW'(SETTLE);
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (i_abort) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_res_valid <= 1'b0;
                  r_dut_in    <= '0;
                  r_done      <= 1'b0;
               end else if (r_cnt == c_CW'(1)) begin
                  r_cnt       <= '0;
                  r_res_data  <= i_dut_out;
                  r_res_idx   <= r_idx;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_OUT;
               end else begin
                  r_cnt <= r_cnt - c_CW'(1);
               end
            end
            ST_OUT: begin
               // abort outranks a handshake landing on the same edge
               if (i_abort) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_res_valid <= 1'b0;
                  r_dut_in    <= '0;
                  r_done      <= 1'b0;
               end else if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  if (r_idx == c_IDX_LAST) begin
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_dut_in <= '0;
                     r_state  <= ST_DONE;
                  end else begin
                     r_idx    <= r_idx + N_IN'(1);
                     r_dut_in <= r_idx + N_IN'(1);
                     r_cnt    <= c_CW'(SETTLE);
                     r_state  <= ST_SETTLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   tt_sweep_sig #(
      .N_OUT (N_OUT),
      .SIG_W (SIG_W)
   ) u_sig (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_start_ok),
      .i_upd  (w_capture),
      .i_data (i_dut_out),
      .o_sig  (o_signature)
   );

   assign o_dut_in    = r_dut_in;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_res_valid = r_res_valid;
   assign o_res_idx   = r_res_idx;
   assign o_res_data  = r_res_data;

`ifdef TT_SWEEP_CHECK_EN
   logic [N_IN:0]   r_err_cnt;
   logic            r_err_seen;
   logic [N_IN-1:0] r_first_err_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt       <= '0;
         r_err_seen      <= 1'b0;
         r_first_err_idx <= '0;
      end else if (w_start_ok) begin
         r_err_cnt       <= '0;
         r_err_seen      <= 1'b0;
         r_first_err_idx <= '0;
      end else if (w_capture && (i_dut_out != i_exp_out)) begin
         if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
         end
         r_err_seen <= 1'b1;
         if (!r_err_seen) begin
            r_first_err_idx <= r_idx;
         end
      end
   end

   assign o_err_cnt       = r_err_cnt;
   assign o_err_seen      = r_err_seen;
   assign o_first_err_idx = r_first_err_idx;
`endif

endmodule

`default_nettype wire
